// File: rtl/mc_ctrl_unit_pkg.sv
// Shared definitions for the multi-cycle control unit: state and instruction-class
// encodings, ALU_OP and PC_s codes, and the registered strobe bundle.
package mc_ctrl_unit_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StFetch,
    StDecode,
    StExec,
    StWb,
    StBxPc,
    StBCalc,
    StBPc,
    StBlLr,
    StBlCalc,
    StMemAddr,
    StMemAcc,
    StMemWb,
    StTrap
  } st_e;

  typedef enum logic [2:0] {
    ClsDp0,
    ClsDp1,
    ClsDp2,
    ClsB,
    ClsBl,
    ClsBx,
    ClsLdst,
    ClsUnd
  } cls_e;

  localparam logic [3:0] AluAdd   = 4'b0100;
  localparam logic [3:0] AluSub   = 4'b0010;
  localparam logic [3:0] AluPassA = 4'b1000;

  localparam logic [1:0] PcInc = 2'b00;
  localparam logic [1:0] PcReg = 2'b01;
  localparam logic [1:0] PcAlu = 2'b10;

  typedef struct packed {
    logic       write_pc;
    logic       write_ir;
    logic       write_reg;
    logic       s;
    logic       la;
    logic       lb;
    logic       lc;
    logic       lf;
    logic       rd_s;
    logic       alu_a_s;
    logic       alu_b_s;
    logic       rm_imm_s;
    logic [1:0] rs_imm_s;
    logic [1:0] pc_s;
    logic [3:0] alu_op;
    logic       mem_req;
    logic       mem_wr;
    logic       mem_imm_s;
  } ctrl_t;

  // TST/TEQ/CMP/CMN reuse the AND/EOR/SUB/ADD encodings.
  function automatic logic [3:0] cmp_alu_op(logic [1:0] op_lo);
    return 4'b1000 >> (3'd4 - {1'b0, op_lo});
  endfunction

endpackage

// File: rtl/mc_inst_decode.sv
// Instruction class decoder: IR -> class and undefined flag.
// Load/store decode is present only when CTRL_LDST_EN is defined.
module mc_inst_decode
  import mc_ctrl_unit_pkg::*;
(
  input  logic [31:0] ir,
  output cls_e        inst_class,
  output logic        undef
);

  logic unused_ir;
  assign unused_ir = ^{ir[31:28], ir[3:0]};

  always_comb begin
    inst_class = ClsUnd;
    // BX overlaps the DP1 pattern, so it is matched first.
    if (ir[27:4] == 24'h12FFF1) begin
      inst_class = ClsBx;
    end else begin
      case (ir[27:25])
        3'b000: begin
          if (!ir[4]) begin
            inst_class = ClsDp0;
          end else if (!ir[7]) begin
            inst_class = ClsDp1;
          end
        end
        3'b001: inst_class = ClsDp2;
        3'b101: inst_class = ir[24] ? ClsBl : ClsB;
`ifdef CTRL_LDST_EN
        3'b010: inst_class = ClsLdst;
`endif
        default: inst_class = ClsUnd;
      endcase
    end
  end

  assign undef = (inst_class == ClsUnd);

endmodule

// File: rtl/mc_ctrl_unit.sv
// Multi-cycle control unit FSM; every output is registered from the next state.
// Define CTRL_LDST_EN to include load/store states, memory strobes and the bus timeout.
module mc_ctrl_unit
  import mc_ctrl_unit_pkg::*;
#(
  parameter int TO_W    = 4,
  parameter int TIMEOUT = 12,
  parameter int ST_W    = 4
) (
  input  logic            clk,
  input  logic            Rst_n,
  input  logic [31:0]     IR,
  input  logic            flag,
  input  logic            Mem_Ready,
  output logic            Write_PC,
  output logic            Write_IR,
  output logic            Write_Reg,
  output logic            S,
  output logic            LA,
  output logic            LB,
  output logic            LC,
  output logic            LF,
  output logic            rd_s,
  output logic            ALU_A_s,
  output logic            ALU_B_s,
  output logic            rm_imm_s,
  output logic [1:0]      rs_imm_s,
  output logic [1:0]      PC_s,
  output logic [3:0]      ALU_OP,
  output logic            Mem_Req,
  output logic            Mem_Wr,
  output logic            Mem_Imm_s,
  output logic            Und_Trap,
  output logic            Bus_Err,
  output logic [ST_W-1:0] State
);

  st_e   st_q, st_d;
  ctrl_t ctrl_q, ctrl_d;
  cls_e  inst_class;
  logic  undef;
  logic  und_q, und_d;

  mc_inst_decode u_decode (
    .ir        (IR),
    .inst_class(inst_class),
    .undef     (undef)
  );

`ifdef CTRL_LDST_EN
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            berr_q, berr_d;
`else
  logic            unused_mem;
  logic [TO_W-1:0] unused_to;
  assign unused_mem = Mem_Ready;
  assign unused_to  = TO_W'(TIMEOUT);
`endif

  always_comb begin
    st_d  = st_q;
    und_d = und_q;
`ifdef CTRL_LDST_EN
    to_cnt_d = to_cnt_q;
    berr_d   = berr_q;
`endif
    case (st_q)
      StIdle:   st_d = StFetch;
      StFetch: begin
        if (undef) begin
          st_d  = StTrap;
          und_d = 1'b1;
        end else if (!flag) begin
          st_d = StFetch;
        end else if (inst_class == ClsB) begin
          st_d = StBCalc;
        end else if (inst_class == ClsBl) begin
          st_d = StBlLr;
        end else begin
          st_d = StDecode;
        end
      end
      StDecode: begin
        if (inst_class == ClsBx) begin
          st_d = StBxPc;
        end else if (inst_class == ClsLdst) begin
          st_d = StMemAddr;
        end else begin
          st_d = StExec;
        end
      end
      StExec:   st_d = StWb;
      StWb:     st_d = StFetch;
      StBxPc:   st_d = StFetch;
      StBCalc:  st_d = StBPc;
      StBPc:    st_d = StFetch;
      StBlLr:   st_d = StBlCalc;
      StBlCalc: st_d = StBPc;
`ifdef CTRL_LDST_EN
      StMemAddr: begin
        st_d     = StMemAcc;
        to_cnt_d = '0;
      end
      StMemAcc: begin
        // Ready on the final allowed cycle still completes the access.
        if (Mem_Ready) begin
          st_d = IR[20] ? StMemWb : StFetch;
        end else if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
          st_d     = StTrap;
          berr_d   = 1'b1;
          to_cnt_d = to_cnt_q + TO_W'(1);
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      StMemWb:  st_d = StFetch;
`endif
      StTrap:   st_d = StTrap;
      default:  st_d = StIdle;
    endcase
  end

  always_comb begin
    ctrl_d = '0;
    case (st_d)
      StFetch: begin
        ctrl_d.write_pc = 1'b1;
        ctrl_d.write_ir = 1'b1;
        ctrl_d.pc_s     = PcInc;
      end
      StDecode: begin
        ctrl_d.la = 1'b1;
        ctrl_d.lb = 1'b1;
        ctrl_d.lc = 1'b1;
      end
      StExec: begin
        ctrl_d.lf       = 1'b1;
        ctrl_d.s        = IR[20];
        ctrl_d.rm_imm_s = (inst_class == ClsDp2);
        case (inst_class)
          ClsDp1:  ctrl_d.rs_imm_s = 2'b01;
          ClsDp2:  ctrl_d.rs_imm_s = 2'b10;
          default: ctrl_d.rs_imm_s = 2'b00;
        endcase
        ctrl_d.alu_op = (IR[24:23] == 2'b10) ? cmp_alu_op(IR[22:21]) : IR[24:21];
      end
      StWb:     ctrl_d.write_reg = !IR[24] | IR[23];
      StBxPc: begin
        ctrl_d.write_pc = 1'b1;
        ctrl_d.pc_s     = PcReg;
      end
      StBCalc: begin
        ctrl_d.lf      = 1'b1;
        ctrl_d.alu_a_s = 1'b1;
        ctrl_d.alu_b_s = 1'b1;
        ctrl_d.alu_op  = AluAdd;
      end
      StBPc: begin
        ctrl_d.write_pc = 1'b1;
        ctrl_d.pc_s     = PcAlu;
      end
      StBlLr: begin
        ctrl_d.lf      = 1'b1;
        ctrl_d.alu_a_s = 1'b1;
        ctrl_d.alu_op  = AluPassA;
      end
      StBlCalc: begin
        ctrl_d.write_reg = 1'b1;
        ctrl_d.rd_s      = 1'b1;
        ctrl_d.lf        = 1'b1;
        ctrl_d.alu_a_s   = 1'b1;
        ctrl_d.alu_b_s   = 1'b1;
        ctrl_d.alu_op    = AluAdd;
      end
`ifdef CTRL_LDST_EN
      StMemAddr: begin
        ctrl_d.lf        = 1'b1;
        ctrl_d.mem_imm_s = 1'b1;
        ctrl_d.alu_op    = IR[23] ? AluAdd : AluSub;
      end
      StMemAcc: begin
        ctrl_d.mem_req = 1'b1;
        ctrl_d.mem_wr  = !IR[20];
      end
      StMemWb:  ctrl_d.write_reg = 1'b1;
`endif
      default:  ctrl_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge Rst_n) begin
    if (!Rst_n) begin
      st_q   <= StIdle;
      ctrl_q <= '0;
      und_q  <= 1'b0;
    end else begin
      st_q   <= st_d;
      ctrl_q <= ctrl_d;
      und_q  <= und_d;
    end
  end

`ifdef CTRL_LDST_EN
  always_ff @(posedge clk or negedge Rst_n) begin
    if (!Rst_n) begin
      to_cnt_q <= '0;
      berr_q   <= 1'b0;
    end else begin
      to_cnt_q <= to_cnt_d;
      berr_q   <= berr_d;
    end
  end

  assign Bus_Err = berr_q;
`else
  assign Bus_Err = 1'b0;
`endif

  assign Write_PC  = ctrl_q.write_pc;
  assign Write_IR  = ctrl_q.write_ir;
  assign Write_Reg = ctrl_q.write_reg;
  assign S         = ctrl_q.s;
  assign LA        = ctrl_q.la;
  assign LB        = ctrl_q.lb;
  assign LC        = ctrl_q.lc;
  assign LF        = ctrl_q.lf;
  assign rd_s      = ctrl_q.rd_s;
  assign ALU_A_s   = ctrl_q.alu_a_s;
  assign ALU_B_s   = ctrl_q.alu_b_s;
  assign rm_imm_s  = ctrl_q.rm_imm_s;
  assign rs_imm_s  = ctrl_q.rs_imm_s;
  assign PC_s      = ctrl_q.pc_s;
  assign ALU_OP    = ctrl_q.alu_op;
  assign Mem_Req   = ctrl_q.mem_req;
  assign Mem_Wr    = ctrl_q.mem_wr;
  assign Mem_Imm_s = ctrl_q.mem_imm_s;
  assign Und_Trap  = und_q;
  assign State     = ST_W'(st_q);

endmodule

// File: tb/tb_mc_ctrl_unit.sv
// Self-checking bench for mc_ctrl_unit: per-instruction expected traces derived from the
// instruction rules, random instruction mix, memory latency and reset aborts.
module tb_mc_ctrl_unit;
  import mc_ctrl_unit_pkg::*;

  localparam int TO_W    = 4;
  localparam int TIMEOUT = 12;
  localparam int ST_W    = 4;

  logic        clk   = 1'b0;
  logic        Rst_n = 1'b1;
  logic [31:0] IR    = '0;
  logic        flag  = 1'b0;
  logic        Mem_Ready = 1'b0;
  logic Write_PC, Write_IR, Write_Reg, S, LA, LB, LC, LF, rd_s, ALU_A_s, ALU_B_s, rm_imm_s;
  logic [1:0] rs_imm_s, PC_s;
  logic [3:0] ALU_OP;
  logic Mem_Req, Mem_Wr, Mem_Imm_s, Und_Trap, Bus_Err;
  logic [ST_W-1:0] State;

  mc_ctrl_unit #(.TO_W(TO_W), .TIMEOUT(TIMEOUT), .ST_W(ST_W)) dut (
    .clk(clk), .Rst_n(Rst_n), .IR(IR), .flag(flag), .Mem_Ready(Mem_Ready),
    .Write_PC(Write_PC), .Write_IR(Write_IR), .Write_Reg(Write_Reg), .S(S),
    .LA(LA), .LB(LB), .LC(LC), .LF(LF), .rd_s(rd_s), .ALU_A_s(ALU_A_s),
    .ALU_B_s(ALU_B_s), .rm_imm_s(rm_imm_s), .rs_imm_s(rs_imm_s), .PC_s(PC_s),
    .ALU_OP(ALU_OP), .Mem_Req(Mem_Req), .Mem_Wr(Mem_Wr), .Mem_Imm_s(Mem_Imm_s),
    .Und_Trap(Und_Trap), .Bus_Err(Bus_Err), .State(State)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ST_W-1:0] st;
    logic wpc, wir, wreg, s, la, lb, lc, lf, rds, as, bs, rmi;
    logic [1:0] rsi, pcs;
    logic [3:0] op;
    logic mreq, mwr, mimm, und, berr;
  } obs_t;

  typedef enum int {KDp0, KDp1, KDp2, KB, KBl, KBx, KLdst, KUnd} kind_e;

  int tests = 0;
  int fails = 0;
  bit need_reset = 1'b0;

  function automatic obs_t sample();
    obs_t o;
    o.st = State; o.wpc = Write_PC; o.wir = Write_IR; o.wreg = Write_Reg; o.s = S;
    o.la = LA; o.lb = LB; o.lc = LC; o.lf = LF; o.rds = rd_s; o.as = ALU_A_s;
    o.bs = ALU_B_s; o.rmi = rm_imm_s; o.rsi = rs_imm_s; o.pcs = PC_s; o.op = ALU_OP;
    o.mreq = Mem_Req; o.mwr = Mem_Wr; o.mimm = Mem_Imm_s; o.und = Und_Trap;
    o.berr = Bus_Err;
    return o;
  endfunction

  function automatic obs_t in_state(st_e s);
    obs_t o;
    o = '0;
    o.st = ST_W'(s);
    return o;
  endfunction

  function automatic obs_t fetch_exp();
    obs_t o;
    o = in_state(StFetch);
    o.wpc = 1'b1;
    o.wir = 1'b1;
    return o;
  endfunction

  // Instruction classes straight from the ISA bit patterns.
  function automatic kind_e classify(logic [31:0] ir);
    if (ir[27:4] == 24'h12FFF1) return KBx;
    if (ir[27:25] == 3'b000 && !ir[4]) return KDp0;
    if (ir[27:25] == 3'b000 && !ir[7]) return KDp1;
    if (ir[27:25] == 3'b001) return KDp2;
    if (ir[27:25] == 3'b101) return ir[24] ? KBl : KB;
`ifdef CTRL_LDST_EN
    if (ir[27:25] == 3'b010) return KLdst;
`endif
    return KUnd;
  endfunction

  function automatic logic [3:0] exp_alu(logic [3:0] opc);
    case (opc)
      4'b1000: return 4'b0000;  // TST -> AND
      4'b1001: return 4'b0001;  // TEQ -> EOR
      4'b1010: return 4'b0010;  // CMP -> SUB
      4'b1011: return 4'b0100;  // CMN -> ADD
      default: return opc;
    endcase
  endfunction

  function automatic logic [31:0] gen_ir(kind_e k);
    logic [31:0] r;
    logic [2:0]  und_top [4];
    und_top[0] = 3'b011; und_top[1] = 3'b100; und_top[2] = 3'b110; und_top[3] = 3'b111;
    r = $urandom;
    case (k)
      KDp0: begin r[27:25] = 3'b000; r[4] = 1'b0; end
      KDp1: begin
        r[27:25] = 3'b000; r[4] = 1'b1; r[7] = 1'b0;
        if (r[27:4] == 24'h12FFF1) r[20] = ~r[20];
      end
      KDp2:  r[27:25] = 3'b001;
      KB:    begin r[27:25] = 3'b101; r[24] = 1'b0; end
      KBl:   begin r[27:25] = 3'b101; r[24] = 1'b1; end
      KBx:   r[27:4] = 24'h12FFF1;
      KLdst: r[27:25] = 3'b010;
      default: begin
        if ($urandom_range(0, 4) == 0) begin
          r[27:25] = 3'b000; r[4] = 1'b1; r[7] = 1'b1;
        end else begin
          r[27:25] = und_top[$urandom_range(0, 3)];
        end
      end
    endcase
    return r;
  endfunction

  task automatic check(input string tag, input obs_t exp);
    obs_t o;
    o = sample();
    tests++;
    assert (o === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, o, exp);
    end
  endtask

  task automatic step(input logic rdy, input string tag, input obs_t exp);
    Mem_Ready = rdy;
    @(posedge clk);
    #1;
    check(tag, exp);
  endtask

  function automatic logic noise();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic do_reset();
    Rst_n = 1'b0;
    #1;
    check("reset_async", in_state(StIdle));
    @(negedge clk);
    @(negedge clk);
    check("reset_held", in_state(StIdle));
    Rst_n = 1'b1;
    step(noise(), "first_fetch", fetch_exp());
    need_reset = 1'b0;
  endtask

  // lat: waiting cycles before Mem_Ready (>= TIMEOUT means never);
  // abort: MEM_ACC cycle at which reset is pulsed (-1 for none).
  task automatic run_instr(input logic [31:0] ir, input logic fl, input int lat, input int abort);
    kind_e k;
    obs_t  e;
    IR   = ir;
    flag = fl;
    k    = classify(ir);
    if (k == KUnd) begin
      e = in_state(StTrap);
      e.und = 1'b1;
      step(noise(), "und_trap", e);
      step(noise(), "trap_hold", e);
      need_reset = 1'b1;
      return;
    end
    if (!fl) begin
      step(noise(), "fetch_noflag", fetch_exp());
      return;
    end
    if (k == KB || k == KBl) begin
      if (k == KB) begin
        e = in_state(StBCalc); e.lf = 1; e.as = 1; e.bs = 1; e.op = 4'b0100;
        step(noise(), "b_calc", e);
      end else begin
        e = in_state(StBlLr); e.lf = 1; e.as = 1; e.op = 4'b1000;
        step(noise(), "bl_lr", e);
        e = in_state(StBlCalc); e.wreg = 1; e.rds = 1; e.lf = 1; e.as = 1; e.bs = 1;
        e.op = 4'b0100;
        step(noise(), "bl_calc", e);
      end
      e = in_state(StBPc); e.wpc = 1; e.pcs = 2'b10;
      step(noise(), "b_pc", e);
      step(noise(), "fetch_after_b", fetch_exp());
      return;
    end
    e = in_state(StDecode); e.la = 1; e.lb = 1; e.lc = 1;
    step(noise(), "decode", e);
    if (k == KBx) begin
      e = in_state(StBxPc); e.wpc = 1; e.pcs = 2'b01;
      step(noise(), "bx_pc", e);
      step(noise(), "fetch_after_bx", fetch_exp());
      return;
    end
    if (k == KLdst) begin
      e = in_state(StMemAddr); e.lf = 1; e.mimm = 1; e.op = ir[23] ? 4'b0100 : 4'b0010;
      step(noise(), "mem_addr", e);
      e = in_state(StMemAcc); e.mreq = 1; e.mwr = !ir[20];
      step(noise(), "mem_acc_entry", e);
      for (int c = 0; c < TIMEOUT; c++) begin
        if (abort == c) begin
          do_reset();
          return;
        end
        if (c == lat) begin
          if (ir[20]) begin
            e = in_state(StMemWb); e.wreg = 1;
            step(1'b1, "mem_wb", e);
            step(noise(), "fetch_after_ld", fetch_exp());
          end else begin
            step(1'b1, "fetch_after_st", fetch_exp());
          end
          return;
        end
        if (c == TIMEOUT - 1) begin
          e = in_state(StTrap); e.berr = 1;
          step(1'b0, "bus_err", e);
          step(noise(), "bus_err_hold", e);
          need_reset = 1'b1;
          return;
        end
        e = in_state(StMemAcc); e.mreq = 1; e.mwr = !ir[20];
        step(1'b0, "mem_wait", e);
      end
      return;
    end
    e = in_state(StExec); e.lf = 1; e.s = ir[20]; e.rmi = (k == KDp2);
    e.rsi = (k == KDp0) ? 2'b00 : (k == KDp1) ? 2'b01 : 2'b10;
    e.op  = exp_alu(ir[24:21]);
    step(noise(), "exec", e);
    e = in_state(StWb); e.wreg = (ir[24:23] != 2'b10);
    step(noise(), "wb", e);
    step(noise(), "fetch_after_dp", fetch_exp());
  endtask

  initial begin
    kind_e k;
    int    lat;
    int    abort;
    #2;
    do_reset();

    run_instr(32'hE2821005, 1'b1, 0, -1);  // ADD r1,r2,#5
    run_instr(32'hE1510002, 1'b1, 0, -1);  // CMP r1,r2
    run_instr(32'hEB000004, 1'b1, 0, -1);  // BL
    run_instr(32'hEA000004, 1'b1, 0, -1);  // B
    run_instr(32'hE12FFF11, 1'b1, 0, -1);  // BX r1
    for (int i = 0; i < 3; i++) run_instr(32'h02821005, 1'b0, 0, -1);
    run_instr(32'hE5921004, 1'b1, 3, -1);  // LDR, ready after 3 waits
    if (need_reset) do_reset();
`ifdef CTRL_LDST_EN
    run_instr(32'hE5821004, 1'b1, TIMEOUT + 5, -1);  // STR, never ready
    if (need_reset) do_reset();
    run_instr(32'hE5821004, 1'b1, TIMEOUT + 5, 5);   // STR, reset mid-wait
    run_instr(32'hE5121004, 1'b1, TIMEOUT - 1, -1);  // LDR, ready on last cycle
    if (need_reset) do_reset();
`endif
    run_instr(32'hE7F000F0, 1'b1, 0, -1);  // undefined
    if (need_reset) do_reset();

    for (int i = 0; i < 150; i++) begin
      k     = ($urandom_range(0, 19) == 0) ? KUnd : kind_e'($urandom_range(0, 6));
      lat   = $urandom_range(0, TIMEOUT + 1);
      abort = ($urandom_range(0, 9) == 0) ? $urandom_range(0, TIMEOUT - 1) : -1;
      run_instr(gen_ir(k), ($urandom_range(0, 5) != 0), lat, abort);
      if (need_reset) do_reset();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
